// File: rtl/acc_dump_decimator.sv
// Accumulate-and-dump decimator: averages every 2**DECIM_LOG2 valid samples into a small FWFT output FIFO.
// Optional build macro ACC_DUMP_ROUND_EN selects round-half-up instead of floor for the mean.
module acc_dump_decimator #(
  parameter int WORDLENGTH        = 14,
  parameter int FRACTIONAL_LENGTH = 6,
  parameter int DECIM_LOG2        = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [WORDLENGTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic [WORDLENGTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  drop
);
  // Handshake: a result leaves the FIFO on any edge where m_tvalid && m_tready;
  // m_tdata/m_tvalid hold steady while m_tvalid=1 and m_tready=0. Input has no ready.

  localparam int AW = WORDLENGTH + DECIM_LOG2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int N  = 1 << DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic [PW:0]           FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic signed [AW-1:0]   r_acc;
  logic [DECIM_LOG2-1:0]  r_cnt;
  logic [WORDLENGTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PW:0]            r_wptr;
  logic [PW:0]            r_rptr;
  logic                   r_drop;

  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_rsum;
  logic [WORDLENGTH-1:0]  w_result;
  logic [DECIM_LOG2-1:0]  w_unused_frac;
  logic [PW:0]            w_count;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push_req;
  logic                   w_push;

  assign w_sum = r_acc + {{DECIM_LOG2{s_tdata[WORDLENGTH-1]}}, s_tdata};

`ifdef ACC_DUMP_ROUND_EN
  assign w_rsum = w_sum + AW'(N / 2);
`else
  assign w_rsum = w_sum;
`endif

  // Low WORDLENGTH bits of the arithmetic shift; the mean always fits.
  assign w_result      = w_rsum[DECIM_LOG2 +: WORDLENGTH];
  assign w_unused_frac = w_rsum[DECIM_LOG2-1:0];

  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (w_count == FULL_CNT);
  assign w_pop      = !w_empty && m_tready;
  assign w_push_req = s_tvalid && (r_cnt == CNT_LAST);
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_drop <= 1'b0;
    end else begin
      if (s_tvalid) begin
        if (r_cnt == CNT_LAST) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push_req && !w_push) r_drop <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= w_result;
  end

  assign m_tvalid = !w_empty;
  assign m_tdata  = w_empty ? '0 : r_mem[r_rptr[PW-1:0]];
  assign drop     = r_drop;

endmodule

// File: tb/tb_acc_dump_decimator.sv
// Directed bench for acc_dump_decimator: frame-average vectors plus FIFO full/drop/reset sequences.
// Build with ACC_DUMP_ROUND_EN defined to check the rounding variant.
module tb_acc_dump_decimator;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         srst = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         drop;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int s0, s1, s2, s3;
    int exp_trunc;
    int exp_round;
  } vec_t;

  vec_t vecs[9];

  acc_dump_decimator #(
    .WORDLENGTH(14), .FRACTIONAL_LENGTH(6), .DECIM_LOG2(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .srst(srst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .drop(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(m_tdata));
  endfunction

  task automatic do_reset();
    srst = 1'b1;
    s_tvalid = 1'b0;
    tick();
    srst = 1'b0;
  endtask

  task automatic drive_sample(input int v, input bit gap);
    s_tdata = v[W-1:0];
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    if (gap) tick();
  endtask

  task automatic drive_group(input int v, input bit gap);
    for (int s = 0; s < 4; s++) drive_sample(v, gap);
  endtask

  task automatic drain_check(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 16) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check({name, "_valid"}, int'(m_tvalid), 1);
      check({name, "_data"}, sdata(), int'($signed(e)));
      tick();
      k++;
    end
    check({name, "_empty"}, int'(m_tvalid), 0);
  endtask

  initial begin
    int exp_v;
    // s0..s3, floor result, round-half-up result
    vecs[0] = '{64, 64, 64, 64, 64, 64};
    vecs[1] = '{0, 1, 2, 3, 1, 2};
    vecs[2] = '{-1, -1, -1, -2, -2, -1};
    vecs[3] = '{8191, 8191, 8191, 8191, 8191, 8191};
    vecs[4] = '{-8192, -8192, -8192, -8192, -8192, -8192};
    vecs[5] = '{100, -50, 7, 0, 14, 14};
    vecs[6] = '{-3, 0, 0, 0, -1, -1};
    vecs[7] = '{2, 0, 0, 0, 0, 1};
    vecs[8] = '{-8192, 8191, -8192, 8191, -1, 0};

    do_reset();
    check("reset_valid", int'(m_tvalid), 0);
    check("reset_data", sdata(), 0);
    check("reset_drop", int'(drop), 0);

    // DC run: 8 contiguous samples of 1.0, outputs pulse after edges 4 and 8.
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tdata = 14'd64;
      s_tvalid = 1'b1;
      tick();
      check("dc_valid", int'(m_tvalid), (i == 3 || i == 7) ? 1 : 0);
      if (i == 3 || i == 7) check("dc_data", sdata(), 64);
    end
    s_tvalid = 1'b0;
    tick();
    check("dc_valid_end", int'(m_tvalid), 0);
    check("dc_drop", int'(drop), 0);

    // Table of single frames with hand-computed means.
    for (int i = 0; i < 9; i++) begin
`ifdef ACC_DUMP_ROUND_EN
      exp_v = vecs[i].exp_round;
`else
      exp_v = vecs[i].exp_trunc;
`endif
      drive_sample(vecs[i].s0, 1'b0);
      drive_sample(vecs[i].s1, 1'b1);
      drive_sample(vecs[i].s2, 1'b0);
      drive_sample(vecs[i].s3, 1'b0);
      check($sformatf("vec%0d_valid", i), int'(m_tvalid), 1);
      check($sformatf("vec%0d_data", i), sdata(), exp_v);
      tick();
      check($sformatf("vec%0d_popped", i), int'(m_tvalid), 0);
    end

    // Gaps and backpressure: fill the FIFO, then overflow once.
    do_reset();
    m_tready = 1'b0;
    for (int k = 1; k <= 4; k++) drive_group(k, 1'b1);
    check("bp_full_valid", int'(m_tvalid), 1);
    check("bp_full_head", sdata(), 1);
    check("bp_full_drop", int'(drop), 0);
    drive_group(5, 1'b1);
    check("bp_overflow_drop", int'(drop), 1);
    check("bp_overflow_head", sdata(), 1);
    for (int k = 1; k <= 4; k++) exp_q.push_back(W'(k));
    m_tready = 1'b1;
    drain_check("bp_drain");
    check("bp_drop_sticky", int'(drop), 1);
    do_reset();
    check("bp_drop_cleared", int'(drop), 0);

    // Full FIFO with a pop on the dump edge: result must be accepted.
    m_tready = 1'b0;
    for (int k = 1; k <= 4; k++) drive_group(k, 1'b0);
    drive_sample(5, 1'b0);
    drive_sample(5, 1'b0);
    drive_sample(5, 1'b0);
    check("fp_head_before", sdata(), 1);
    m_tready = 1'b1;
    drive_sample(5, 1'b0);
    check("fp_drop", int'(drop), 0);
    for (int k = 2; k <= 5; k++) exp_q.push_back(W'(k));
    drain_check("fp_drain");
    check("fp_drop_end", int'(drop), 0);

    // Reset in the middle of a frame discards the partial sum.
    drive_sample(1000, 1'b0);
    drive_sample(1000, 1'b0);
    srst = 1'b1;
    tick();
    check("mr_valid_in_reset", int'(m_tvalid), 0);
    check("mr_drop_in_reset", int'(drop), 0);
    srst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_sample(64, 1'b0);
      if (i < 3) check("mr_no_early", int'(m_tvalid), 0);
    end
    check("mr_valid", int'(m_tvalid), 1);
    check("mr_data", sdata(), 64);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mr_single", int'(m_tvalid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
